// File: rtl/stream_mac_scheduler.sv
// Round-robin scheduler that time-shares one streaming multiply-accumulate datapath between
// NUM_REQ requesters, sequencing each dot-product job from accept through MAC drain to result.
module stream_mac_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16,
  parameter int LEN_W   = 8,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         req_ack,
  input  logic [NUM_REQ-1:0]         op_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  op_a,
  input  logic [NUM_REQ*DATA_W-1:0]  op_b,
  output logic [NUM_REQ-1:0]         op_ready,
  output logic                       mac_en,
  output logic                       mac_first,
  output logic [DATA_W-1:0]          mac_a,
  output logic [DATA_W-1:0]          mac_b,
  input  logic [ACC_W-1:0]           mac_result,
  output logic                       res_valid,
  output logic [ACC_W-1:0]           res_data,
  output logic [IDW-1:0]             res_id,
  input  logic                       res_ready,
  output logic [1:0]                 dbg_state
);

  // Handshakes: an operand beat moves on a rising edge where op_valid[i] & op_ready[i]; a result
  // moves where res_valid & res_ready. req_ack is a single-cycle accept pulse, not a handshake.
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_RESP} state_t;

  state_t           state, next_state;
  logic [IDW-1:0]   last_grant, id, gnt;
  logic [LEN_W-1:0] cnt, glen;
  logic             first, found, beat;
  int               idx;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  assign glen      = req_len[gnt*LEN_W +: LEN_W];
  assign beat      = (state == S_STREAM) && op_valid[id];
  assign res_valid = (state == S_RESP);
  assign dbg_state = state;

  always_comb begin
    next_state = state;
    req_ack    = '0;
    op_ready   = '0;
    mac_en     = 1'b0;
    mac_first  = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    case (state)
      S_IDLE: begin
        if (found && !reset) begin
          req_ack[gnt] = 1'b1;
          next_state   = (glen == '0) ? S_RESP : S_STREAM;
        end
      end
      S_STREAM: begin
        op_ready[id] = 1'b1;
        if (beat) begin
          mac_en    = 1'b1;
          mac_first = first;
          mac_a     = op_a[id*DATA_W +: DATA_W];
          mac_b     = op_b[id*DATA_W +: DATA_W];
          if (cnt == LEN_W'(1)) next_state = S_DRAIN;
        end
      end
      S_DRAIN: next_state = S_RESP;
      S_RESP:  if (res_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      id         <= '0;
      cnt        <= '0;
      first      <= 1'b0;
      res_data   <= '0;
      res_id     <= '0;
    end else begin
      state <= next_state;
      case (state)
        S_IDLE: begin
          if (found) begin
            last_grant <= gnt;
            id         <= gnt;
            cnt        <= glen;
            first      <= 1'b1;
            // Zero-length jobs skip the MAC entirely and answer with 0.
            if (glen == '0) begin
              res_data <= '0;
              res_id   <= gnt;
            end
          end
        end
        S_STREAM: begin
          if (beat) begin
            cnt   <= cnt - 1'b1;
            first <= 1'b0;
          end
        end
        S_DRAIN: begin
          res_data <= mac_result;
          res_id   <= id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_mac_scheduler.sv
// Bench for stream_mac_scheduler: directed jobs plus randomized concurrent requesters, with a
// behavioural MAC, a dot-product reference computed from the issued operands and a result scoreboard.
module tb_stream_mac_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 16;
  localparam int LEN_W   = 8;
  localparam int IDW     = 2;
  localparam int EW      = IDW + LEN_W + ACC_W;

  logic                      clk, reset;
  logic [NUM_REQ-1:0]        req_valid, req_ack, op_valid, op_ready;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ*DATA_W-1:0] op_a, op_b;
  logic                      mac_en, mac_first, res_valid, res_ready;
  logic [DATA_W-1:0]         mac_a, mac_b;
  logic [ACC_W-1:0]          mac_result, res_data;
  logic [IDW-1:0]            res_id;
  logic [1:0]                dbg_state;

  stream_mac_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_len(req_len), .req_ack(req_ack),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .mac_en(mac_en),
    .mac_first(mac_first), .mac_a(mac_a), .mac_b(mac_b), .mac_result(mac_result),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural MAC: registered accumulator, wraps at ACC_W bits.
  logic [ACC_W-1:0] acc;
  assign mac_result = acc;
  always @(posedge clk or posedge reset) begin
    if (reset) acc <= '0;
    else if (mac_en) begin
      if (mac_first) acc <= ACC_W'($signed(mac_a) * $signed(mac_b));
      else           acc <= acc + ACC_W'($signed(mac_a) * $signed(mac_b));
    end
  end

  // ---------------- scoreboard state ----------------
  int               n_vec, n_err;
  logic [EW-1:0]    exp_q[$];
  logic signed [DATA_W-1:0] job_a [NUM_REQ][256];
  logic signed [DATA_W-1:0] job_b [NUM_REQ][256];
  int               model_last, beats_in_job, resp_stall;
  bit               resp_active, rnd_ready;
  logic [ACC_W-1:0] held_data;
  logic [IDW-1:0]   held_id;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_job(input int i, input int len, input int gap_pct, input int gap_at,
                         input int gap_len);
    int sum;
    bit got;
    sum = 0;
    for (int k = 0; k < len; k++) sum += int'(job_a[i][k]) * int'(job_b[i][k]);
    req_len[i*LEN_W +: LEN_W] = LEN_W'(len);
    req_valid[i] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clk);
      if (req_ack[i]) got = 1'b1;
    end
    if (!got) begin
      check("ack_timeout", i, -1);
      req_valid[i] = 1'b0;
      return;
    end
    exp_q.push_back({IDW'(i), LEN_W'(len), ACC_W'(sum)});
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k == gap_at) begin
        op_valid[i] = 1'b0;
        repeat (gap_len) begin @(posedge clk); #1; end
      end
      if (gap_pct > 0 && $urandom_range(1, 100) <= gap_pct) begin
        op_valid[i] = 1'b0;
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      op_valid[i] = 1'b1;
      op_a[i*DATA_W +: DATA_W] = job_a[i][k];
      op_b[i*DATA_W +: DATA_W] = job_b[i][k];
      got = 1'b0;
      for (int t = 0; t < 3000 && !got; t++) begin
        @(negedge clk);
        if (op_ready[i]) got = 1'b1;
        @(posedge clk); #1;
      end
      if (!got) begin
        check("beat_timeout", i, -1);
        op_valid[i] = 1'b0;
        return;
      end
    end
    op_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !resp_active && !res_valid) done = 1'b1;
    end
    if (!done) check("idle_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_driver(input int i);
    int len;
    for (int j = 0; j < 8; j++) begin
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      len = $urandom_range(0, 9);
      for (int k = 0; k < len; k++) begin
        job_a[i][k] = DATA_W'($urandom);
        job_b[i][k] = DATA_W'($urandom);
      end
      run_job(i, len, 25, -1, 0);
    end
  endtask

  // ---------------- result consumer ----------------
  initial begin
    int left;
    bit seen;
    left = 0;
    seen = 1'b0;
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (res_valid) begin
        if (!seen) begin seen = 1'b1; left = resp_stall; end
      end else seen = 1'b0;
      if (res_valid && left > 0) begin
        res_ready = 1'b0;
        left--;
      end else res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    int e, idx;
    logic [EW-1:0] ent;
    if (reset) begin
      model_last   = NUM_REQ - 1;
      beats_in_job = 0;
      resp_active  = 1'b0;
    end else begin
      if (req_ack != '0) begin
        e = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = (model_last + k) % NUM_REQ;
          if (e < 0 && req_valid[idx]) e = idx;
        end
        check("grant", int'(req_ack), (e < 0) ? 0 : (1 << e));
        if (e >= 0) model_last = e;
        beats_in_job = 0;
      end
      if (mac_en) begin
        check("mac_first", int'(mac_first), (beats_in_job == 0) ? 1 : 0);
        check("mac_a", int'(mac_a), int'(op_a[model_last*DATA_W +: DATA_W]));
        check("mac_b", int'(mac_b), int'(op_b[model_last*DATA_W +: DATA_W]));
        beats_in_job++;
      end else if (mac_first || mac_a != '0 || mac_b != '0) begin
        check("mac_idle_zero", int'({mac_first, mac_a, mac_b}), 0);
      end
      if (res_valid) begin
        if (!resp_active) begin
          if (exp_q.size() == 0) check("res_unexpected", 1, 0);
          else begin
            ent = exp_q.pop_front();
            check("res_id", int'(res_id), int'(ent[EW-1 -: IDW]));
            check("res_data", int'(res_data), int'(ent[ACC_W-1:0]));
            check("beat_count", beats_in_job, int'(ent[ACC_W +: LEN_W]));
          end
          resp_active = 1'b1;
          held_data   = res_data;
          held_id     = res_id;
        end else begin
          check("res_hold_data", int'(res_data), int'(held_data));
          check("res_hold_id", int'(res_id), int'(held_id));
        end
        if (res_ready) resp_active = 1'b0;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit got;
    n_vec = 0; n_err = 0;
    reset = 1'b1;
    req_valid = '0; req_len = '0; op_valid = '0; op_a = '0; op_b = '0;
    resp_stall = 0; rnd_ready = 1'b0;
    model_last = NUM_REQ - 1; beats_in_job = 0; resp_active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ack", int'(req_ack), 0);
    check("rst_op_ready", int'(op_ready), 0);
    check("rst_mac_en", int'(mac_en), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_state", int'(dbg_state), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Round-robin with all four pending; requester 0 comes back for a second job.
    for (int r = 0; r < NUM_REQ; r++)
      for (int k = 0; k < 2; k++) begin
        job_a[r][k] = DATA_W'(r + k + 1);
        job_b[r][k] = DATA_W'(-(r + 2));
      end
    fork
      begin run_job(0, 2, 0, -1, 0); run_job(0, 2, 0, -1, 0); end
      run_job(1, 2, 0, -1, 0);
      run_job(2, 2, 0, -1, 0);
      run_job(3, 2, 0, -1, 0);
    join
    wait_idle();

    // Single job: expected dot product 8.
    job_a[0][0] = 8'sd2;  job_b[0][0] = 8'sd3;
    job_a[0][1] = 8'sd1;  job_b[0][1] = 8'sd4;
    job_a[0][2] = -8'sd1; job_b[0][2] = 8'sd2;
    job_a[0][3] = 8'sd0;  job_b[0][3] = 8'sd0;
    run_job(0, 4, 0, -1, 0);
    wait_idle();

    // Operand gap of two cycles and a three-cycle result stall: expected 6.
    resp_stall = 3;
    job_a[2][0] = 8'sd3;  job_b[2][0] = 8'sd3;
    job_a[2][1] = 8'sd2;  job_b[2][1] = -8'sd2;
    job_a[2][2] = -8'sd1; job_b[2][2] = -8'sd1;
    run_job(2, 3, 0, 1, 2);
    wait_idle();
    resp_stall = 0;

    // Zero-length job.
    run_job(1, 0, 0, -1, 0);
    wait_idle();

    // Longest job with maximal positive operands: accumulator wraps.
    for (int k = 0; k < 255; k++) begin
      job_a[3][k] = 8'sd127;
      job_b[3][k] = 8'sd127;
    end
    run_job(3, 255, 0, -1, 0);
    wait_idle();

    // Reset after the second beat of a four-beat job.
    req_len[0 +: LEN_W] = 8'd4;
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (req_ack[0]) got = 1'b1;
    end
    check("rst_job_ack", int'(got), 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      op_valid[0] = 1'b1;
      op_a[0 +: DATA_W] = DATA_W'(k + 5);
      op_b[0 +: DATA_W] = DATA_W'(k + 7);
      if (k < 2) begin @(posedge clk); #1; end
    end
    #2;
    reset = 1'b1;
    #1;
    check("midrst_req_ack", int'(req_ack), 0);
    check("midrst_op_ready", int'(op_ready), 0);
    check("midrst_mac_en", int'(mac_en), 0);
    check("midrst_mac_first", int'(mac_first), 0);
    check("midrst_mac_ab", int'({mac_a, mac_b}), 0);
    check("midrst_res_valid", int'(res_valid), 0);
    check("midrst_res", int'({res_data, res_id}), 0);
    op_valid[0] = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    job_a[0][0] = -8'sd9; job_b[0][0] = 8'sd11;
    job_a[3][0] = 8'sd4;  job_b[3][0] = 8'sd5;
    fork
      run_job(0, 1, 0, -1, 0);
      run_job(3, 1, 0, -1, 0);
    join
    wait_idle();

    // Randomized concurrent traffic with random operand gaps and result backpressure.
    rnd_ready = 1'b1;
    fork
      rand_driver(0);
      rand_driver(1);
      rand_driver(2);
      rand_driver(3);
    join
    wait_idle();
    check("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
